// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the RAM arbiter slice.
//   - size codes used on the request ports and on ram_switch
//   - default data-RAM capacity in bytes
//   - arbiter FSM state encoding and port identifiers
//   - size_bytes(): number of bytes an access of a given size code touches
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int RAM_BYTES_DEF = 560;

    localparam logic [2:0] SIZE_BYTE = 3'b100;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Bytes covered by an access; 0 for an invalid size code.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// -----------------------------------------------------------------------------
// mem_access_check
// Combinational legality check for one RAM access.
// An access is legal when its size code is valid, the address is naturally
// aligned for that size, and the last byte touched lies inside the RAM.
//
// Ports
//   addr   in  [31:0]  byte address of the access
//   size   in  [2:0]   size code (byte / half / word)
//   legal  out         1 when the access may be issued to the RAM
// -----------------------------------------------------------------------------
module mem_access_check
    import mem_pkg::*;
#(
    parameter int RAM_BYTES = RAM_BYTES_DEF
) (
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    output logic        legal
);

    logic        w_aligned;
    logic [32:0] w_last;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        w_aligned = 1'b0;
        case (size)
            SIZE_BYTE: w_aligned = 1'b1;
            SIZE_HALF: w_aligned = ~addr[0];
            SIZE_WORD: w_aligned = (addr[1:0] == 2'b00);
            default:   w_aligned = 1'b0;
        endcase

        // 33-bit sum so an address near 2^32 cannot wrap back into range.
        w_last = {1'b0, addr} + {30'd0, size_bytes(size)} - 33'd1;
        legal  = w_aligned && (w_last < 33'(RAM_BYTES));
    end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port data RAM between an instruction-fetch port (word
// reads only) and a data port (byte/half/word reads and writes).
// Three-state FSM: IDLE samples requests and latches the winner, SERVE drives
// the RAM for one cycle, RESP presents a one-cycle ack on the granted port.
// Fixed latency: request sampled in cycle N, ack in cycle N+2.
// Ties are resolved round-robin; after reset the data port wins the first tie.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req, i_addr              fetch request / byte address
//   i_ack, i_err, i_rdata      fetch completion pulse, error, read data
//   d_req, d_we, d_size,
//   d_addr, d_wdata            data request, write enable, size, addr, wdata
//   d_ack, d_err, d_rdata      data completion pulse, error, read data
//   ram_ena, ram_we,
//   ram_switch, ram_addr,
//   ram_data_in                RAM enable, write enable, size, addr, wdata
//   ram_data_out               combinational RAM read data
// -----------------------------------------------------------------------------
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int RAM_BYTES = RAM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,

    output logic        ram_ena,
    output logic        ram_we,
    output logic [2:0]  ram_switch,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out
);

    state_t      r_state;
    // Port granted by the most recent arbitration; doubles as the
    // round-robin history, so after reset it points at the fetch port.
    port_t       r_grant;
    logic        r_legal;
    logic        r_we;

    logic        w_pick_d;
    port_t       w_win;
    logic [31:0] w_sel_addr;
    logic [2:0]  w_sel_size;
    logic        w_sel_we;
    logic [31:0] w_sel_wdata;
    logic        w_sel_legal;
    logic [31:0] w_resp_rdata;

    // Data wins when it is the only requester, or on a tie when the fetch
    // port was granted last.
    assign w_pick_d    = d_req & (~i_req | (r_grant == PORT_I));
    assign w_win       = w_pick_d ? PORT_D : PORT_I;

    // The fetch port is always a word read with no write data.
    assign w_sel_addr  = w_pick_d ? d_addr  : i_addr;
    assign w_sel_size  = w_pick_d ? d_size  : SIZE_WORD;
    assign w_sel_we    = w_pick_d & d_we;
    assign w_sel_wdata = w_pick_d ? d_wdata : 32'd0;

    // Legality is judged on the winner's payload as it is latched, so the
    // registered ram_ena is already correct in the first SERVE cycle.
    mem_access_check #(
        .RAM_BYTES (RAM_BYTES)
    ) u_check (
        .addr  (w_sel_addr),
        .size  (w_sel_size),
        .legal (w_sel_legal)
    );

    // Writes and illegal accesses return zero read data.
    assign w_resp_rdata = (r_legal && !r_we) ? ram_data_out : 32'd0;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= PORT_I;
            r_legal     <= 1'b0;
            r_we        <= 1'b0;
            i_ack       <= 1'b0;
            i_err       <= 1'b0;
            i_rdata     <= 32'd0;
            d_ack       <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= 32'd0;
            ram_ena     <= 1'b0;
            ram_we      <= 1'b0;
            ram_switch  <= 3'd0;
            ram_addr    <= 32'd0;
            ram_data_in <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        r_grant     <= w_win;
                        r_legal     <= w_sel_legal;
                        r_we        <= w_sel_we;
                        ram_addr    <= w_sel_addr;
                        ram_switch  <= w_sel_size;
                        ram_data_in <= w_sel_wdata;
                        ram_ena     <= w_sel_legal;
                        ram_we      <= w_sel_legal & w_sel_we;
                        r_state     <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    ram_ena <= 1'b0;
                    ram_we  <= 1'b0;
                    if (r_grant == PORT_D) begin
                        d_rdata <= w_resp_rdata;
                        d_ack   <= 1'b1;
                        d_err   <= ~r_legal;
                    end else begin
                        i_rdata <= w_resp_rdata;
                        i_ack   <= 1'b1;
                        i_err   <= ~r_legal;
                    end
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    i_ack   <= 1'b0;
                    i_err   <= 1'b0;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. A behavioural byte RAM (big-endian,
// zero-extended reads) sits on the RAM port and is preloaded with
// mem[a] = a[7:0]. Stimulus tasks push the expected response into a
// scoreboard queue; a monitor pops and compares on every ack.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;
    import mem_pkg::*;

    localparam int RB = 560;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        ram_ena;
    logic        ram_we;
    logic [2:0]  ram_switch;
    logic [31:0] ram_addr;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;

    always #5 clk = ~clk;

    ram_arbiter #(.RAM_BYTES(RB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_err        (i_err),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_size       (d_size),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_err        (d_err),
        .d_rdata      (d_rdata),
        .ram_ena      (ram_ena),
        .ram_we       (ram_we),
        .ram_switch   (ram_switch),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // ---------------- RAM model ----------------
    logic [7:0] mem [0:RB-1];
    bit         mem_loaded = 1'b0;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (a < RB) return mem[a[9:0]];
        return 8'h00;
    endfunction

    always_comb begin
        ram_data_out = 32'd0;
        case (ram_switch)
            SIZE_BYTE: ram_data_out = {24'd0, rd(ram_addr)};
            SIZE_HALF: ram_data_out = {16'd0, rd(ram_addr), rd(ram_addr + 32'd1)};
            SIZE_WORD: ram_data_out = {rd(ram_addr), rd(ram_addr + 32'd1),
                                       rd(ram_addr + 32'd2), rd(ram_addr + 32'd3)};
            default:   ram_data_out = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < RB; a++) mem[a] <= 8'(a);
            mem_loaded <= 1'b1;
        end else if (ram_ena && ram_we && ram_addr < RB) begin
            case (ram_switch)
                SIZE_BYTE: mem[ram_addr[9:0]] <= ram_data_in[7:0];
                SIZE_HALF: begin
                    mem[ram_addr[9:0]]         <= ram_data_in[15:8];
                    mem[ram_addr[9:0] + 10'd1] <= ram_data_in[7:0];
                end
                SIZE_WORD: begin
                    mem[ram_addr[9:0]]         <= ram_data_in[31:24];
                    mem[ram_addr[9:0] + 10'd1] <= ram_data_in[23:16];
                    mem[ram_addr[9:0] + 10'd2] <= ram_data_in[15:8];
                    mem[ram_addr[9:0] + 10'd3] <= ram_data_in[7:0];
                end
                default: ;
            endcase
        end
    end

    // ---------------- bookkeeping ----------------
    int cyc     = 0;
    int ena_cnt = 0;
    int we_cnt  = 0;
    int n_pass  = 0;
    int n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_ena) ena_cnt <= ena_cnt + 1;
        if (ram_ena && ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] rdata;
        int          at;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    task automatic push(input bit is_d, input bit err, input logic [31:0] rdata,
                        input int at, input string tag);
        exp_t e;
        e.is_d  = is_d;
        e.err   = err;
        e.rdata = rdata;
        e.at    = at;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (i_ack || d_ack)) begin
            check("single_ack", 32'(i_ack & d_ack), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack_queue_depth", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_port"},  32'(d_ack), 32'(e.is_d));
                check({e.tag, "_err"},   32'(d_ack ? d_err : i_err), 32'(e.err));
                check({e.tag, "_rdata"}, d_ack ? d_rdata : i_rdata, e.rdata);
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ack(input bit is_d, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            seen = is_d ? d_ack : i_ack;
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with the DUT idle; returns just after
    // the rising edge that ends the ack cycle.
    task automatic d_txn(input string tag, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit exp_err, input logic [31:0] exp_rdata, input bit hold);
        d_req   = 1'b1;
        d_we    = we;
        d_size  = size;
        d_addr  = addr;
        d_wdata = wdata;
        push(1'b1, exp_err, exp_rdata, cyc + 2, tag);
        if (hold) begin
            wait_ack(1'b1, tag);
        end else begin
            @(posedge clk);
            #1;
            d_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 3'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
    endtask

    task automatic i_txn(input string tag, input logic [31:0] addr,
                         input bit exp_err, input logic [31:0] exp_rdata);
        i_req  = 1'b1;
        i_addr = addr;
        push(1'b0, exp_err, exp_rdata, cyc + 2, tag);
        wait_ack(1'b0, tag);
        i_req  = 1'b0;
        i_addr = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ena0;
        int we0;

        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 3'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({ram_ena, ram_we, i_ack, d_ack, i_err, d_err}), 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_switch", 32'(ram_switch), 32'd0);
        check("rst_ram_data_in", ram_data_in, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);

        // Both ports request from reset and hold: d, i, d, i every 3 cycles.
        i_req  = 1'b1;
        i_addr = 32'h40;
        d_req  = 1'b1;
        d_size = SIZE_WORD;
        d_addr = 32'h20;
        k      = cyc;
        push(1'b1, 1'b0, 32'h20212223, k + 2,  "tie_d0");
        push(1'b0, 1'b0, 32'h40414243, k + 5,  "tie_i0");
        push(1'b1, 1'b0, 32'h20212223, k + 8,  "tie_d1");
        push(1'b0, 1'b0, 32'h40414243, k + 11, "tie_i1");
        rst_n  = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        i_req  = 1'b0;
        i_addr = 32'd0;
        d_req  = 1'b0;
        d_size = 3'd0;
        d_addr = 32'd0;

        // Data port read/write with all sizes.
        d_txn("wr_word10", 1'b1, SIZE_WORD, 32'h10, 32'h12345678, 1'b0, 32'h0, 1'b1);
        d_txn("rd_byte11", 1'b0, SIZE_BYTE, 32'h11, 32'h0, 1'b0, 32'h00000034, 1'b1);
        d_txn("rd_half12", 1'b0, SIZE_HALF, 32'h12, 32'h0, 1'b0, 32'h00005678, 1'b1);
        d_txn("wr_byte13", 1'b1, SIZE_BYTE, 32'h13, 32'hFFFFFFAB, 1'b0, 32'h0, 1'b1);
        d_txn("wr_half14", 1'b1, SIZE_HALF, 32'h14, 32'h0000BEEF, 1'b0, 32'h0, 1'b1);
        d_txn("rd_word10", 1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, 32'h123456AB, 1'b1);
        d_txn("rd_word14", 1'b0, SIZE_WORD, 32'h14, 32'h0, 1'b0, 32'hBEEF1617, 1'b1);
        // Request dropped right after sampling still completes.
        d_txn("rd_drop",   1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0, 32'h123456AB, 1'b0);

        // Fetch never writes, even with a write pending on the idle data port.
        d_we    = 1'b1;
        d_size  = SIZE_WORD;
        d_addr  = 32'h40;
        d_wdata = 32'hFFFFFFFF;
        we0     = we_cnt;
        i_txn("i_fetch40", 32'h40, 1'b0, 32'h40414243);
        check("i_no_ram_we", 32'(we_cnt - we0), 32'd0);
        d_we    = 1'b0;
        d_size  = 3'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        i_txn("i_fetch40_again", 32'h40, 1'b0, 32'h40414243);

        // Illegal accesses: misaligned, out of range, invalid size.
        ena0 = ena_cnt;
        d_txn("rd_word22e", 1'b0, SIZE_WORD, 32'h22E, 32'h0, 1'b1, 32'h0, 1'b1);
        d_txn("rd_word230", 1'b0, SIZE_WORD, 32'h230, 32'h0, 1'b1, 32'h0, 1'b1);
        d_txn("rd_byte230", 1'b0, SIZE_BYTE, 32'h230, 32'h0, 1'b1, 32'h0, 1'b1);
        d_txn("rd_half22f", 1'b0, SIZE_HALF, 32'h22F, 32'h0, 1'b1, 32'h0, 1'b1);
        d_txn("wr_bad_size", 1'b1, 3'b011, 32'h0, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1);
        i_txn("i_fetch230", 32'h230, 1'b1, 32'h0);
        check("illegal_no_ena", 32'(ena_cnt - ena0), 32'd0);

        // Last legal bytes of the RAM, and readback after the bad-size write.
        d_txn("rd_word22c", 1'b0, SIZE_WORD, 32'h22C, 32'h0, 1'b0, 32'h2C2D2E2F, 1'b1);
        d_txn("rd_byte22f", 1'b0, SIZE_BYTE, 32'h22F, 32'h0, 1'b0, 32'h0000002F, 1'b1);
        d_txn("rd_half22e", 1'b0, SIZE_HALF, 32'h22E, 32'h0, 1'b0, 32'h00002E2F, 1'b1);
        d_txn("rd_word0",   1'b0, SIZE_WORD, 32'h0,   32'h0, 1'b0, 32'h00010203, 1'b1);

        // Reset during SERVE of a write aborts it.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_size  = SIZE_WORD;
        d_addr  = 32'h80;
        d_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #2;
        check("serve_ena", 32'(ram_ena), 32'd1);
        rst_n   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 3'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        #1;
        check("abort_ena", 32'(ram_ena), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_d_rdata", d_rdata, 32'd0);
        check("abort_ram_addr", ram_addr, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Round-robin history is back at "fetch last", so data wins the tie.
        i_req  = 1'b1;
        i_addr = 32'h44;
        d_req  = 1'b1;
        d_size = SIZE_WORD;
        d_addr = 32'h80;
        k      = cyc;
        push(1'b1, 1'b0, 32'h80818283, k + 2, "tie2_d");
        push(1'b0, 1'b0, 32'h44454647, k + 5, "tie2_i");
        repeat (6) @(posedge clk);
        #1;
        i_req  = 1'b0;
        i_addr = 32'd0;
        d_req  = 1'b0;
        d_size = 3'd0;
        d_addr = 32'd0;

        d_txn("rd_word80_after_rst", 1'b0, SIZE_WORD, 32'h80, 32'h0, 1'b0, 32'h80818283, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
